// File: rtl/cr_ifu_ibuf_ctrl.sv
// IFU instruction-buffer pointer/occupancy controller: turns bus returns into
// create strobes and decoder consumption into retire strobes, and gates fetch issue.
module cr_ifu_ibuf_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int PTR_W     = 3
) (
  input  logic                 cpuclk,
  input  logic                 cpurst_b,
  input  logic                 ibuf_flush,
  input  logic                 ifu_ibus_req,
  input  logic                 ibus_ifu_grant,
  input  logic                 ibusif_xx_data_vld,
  input  logic                 ibus_half_only,
  input  logic                 dec_retire_vld,
  input  logic                 dec_retire_32,
  output logic [ENTRY_NUM-1:0] entry_create0_en,
  output logic [ENTRY_NUM-1:0] entry_create1_en,
  output logic [ENTRY_NUM-1:0] entry_retire0_en,
  output logic [ENTRY_NUM-1:0] entry_retire1_en,
  output logic [PTR_W-1:0]     ibuf_rptr,
  output logic [PTR_W:0]       ibuf_cnt,
  output logic                 ibuf_empty,
  output logic                 ibuf_fetch_allow,
  output logic                 ibuf_err
);

  // Handshake: a fetch is outstanding from the cycle after ifu_ibus_req &
  // ibus_ifu_grant until the cycle after ibusif_xx_data_vld; only one may be
  // outstanding, and a second grant in that window is flagged and ignored.

  localparam logic [PTR_W+1:0]     ENTRY_NUM_X = (PTR_W+2)'(ENTRY_NUM);
  localparam logic [PTR_W:0]       ALLOW_MAX   = (PTR_W+1)'(ENTRY_NUM - 2);
  localparam logic [ENTRY_NUM-1:0] ONE_HOT0    = ENTRY_NUM'(1);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   cnt;
  logic             pend;
  logic             kill;

  logic [PTR_W-1:0] wptr_p1;
  logic [PTR_W-1:0] rptr_p1;
  logic             create_req;
  logic             create_ok;
  logic             retire_req;
  logic             retire_ok;
  logic             grant_ok;
  logic             grant_err;
  logic [1:0]       create_num;
  logic [1:0]       retire_num;
  logic [1:0]       create_amt;
  logic [1:0]       retire_amt;
  logic [PTR_W+1:0] free_slots;

  assign wptr_p1 = wptr + PTR_W'(1);
  assign rptr_p1 = rptr + PTR_W'(1);

  assign retire_req = dec_retire_vld & ~ibuf_flush;
  assign retire_num = dec_retire_32 ? 2'd2 : 2'd1;
  assign retire_ok  = retire_req & (cnt >= (PTR_W+1)'(retire_num));
  assign retire_amt = retire_ok ? retire_num : 2'd0;

  // Space freed by a same-cycle retire is usable by the incoming data.
  assign create_req = ibusif_xx_data_vld & ~kill & ~ibuf_flush;
  assign create_num = ibus_half_only ? 2'd1 : 2'd2;
  assign free_slots = ENTRY_NUM_X - {1'b0, cnt} + (PTR_W+2)'(retire_amt);
  assign create_ok  = create_req & (free_slots >= (PTR_W+2)'(create_num));
  assign create_amt = create_ok ? create_num : 2'd0;

  assign grant_ok  = ifu_ibus_req & ibus_ifu_grant & ~pend;
  assign grant_err = ifu_ibus_req & ibus_ifu_grant & pend;

  assign entry_create0_en = (create_amt != 2'd0) ? (ONE_HOT0 << wptr)    : '0;
  assign entry_create1_en = create_amt[1]        ? (ONE_HOT0 << wptr_p1) : '0;
  assign entry_retire0_en = (retire_amt != 2'd0) ? (ONE_HOT0 << rptr)    : '0;
  assign entry_retire1_en = retire_amt[1]        ? (ONE_HOT0 << rptr_p1) : '0;

  assign ibuf_err = (retire_req & ~retire_ok) | (create_req & ~create_ok) | grant_err;

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (ibuf_flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= wptr + PTR_W'(create_amt);
      rptr <= rptr + PTR_W'(retire_amt);
      cnt  <= cnt + (PTR_W+1)'(create_amt) - (PTR_W+1)'(retire_amt);
    end
  end

  // kill marks the in-flight fetch as belonging to a flushed stream so its
  // data is dropped instead of landing in the fresh buffer.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      pend <= 1'b0;
      kill <= 1'b0;
    end else begin
      if (grant_ok)
        pend <= 1'b1;
      else if (ibusif_xx_data_vld)
        pend <= 1'b0;
      if (ibuf_flush)
        kill <= pend & ~ibusif_xx_data_vld;
      else if (ibusif_xx_data_vld)
        kill <= 1'b0;
    end
  end

  assign ibuf_rptr        = rptr;
  assign ibuf_cnt         = cnt;
  assign ibuf_empty       = (cnt == '0);
  assign ibuf_fetch_allow = ~pend & (cnt <= ALLOW_MAX);

endmodule

// File: tb/tb_cr_ifu_ibuf_ctrl.sv
// Bench for cr_ifu_ibuf_ctrl: directed vector table, corner sequences and
// random traffic checked against a queue-of-occupied-entries reference model.
module tb_cr_ifu_ibuf_ctrl;

  localparam int N = 8;
  localparam int PW = 3;

  logic          cpuclk;
  logic          cpurst_b;
  logic          ibuf_flush;
  logic          ifu_ibus_req;
  logic          ibus_ifu_grant;
  logic          ibusif_xx_data_vld;
  logic          ibus_half_only;
  logic          dec_retire_vld;
  logic          dec_retire_32;
  logic [N-1:0]  entry_create0_en;
  logic [N-1:0]  entry_create1_en;
  logic [N-1:0]  entry_retire0_en;
  logic [N-1:0]  entry_retire1_en;
  logic [PW-1:0] ibuf_rptr;
  logic [PW:0]   ibuf_cnt;
  logic          ibuf_empty;
  logic          ibuf_fetch_allow;
  logic          ibuf_err;

  int checks;
  int failures;

  // reference model: ordered list of occupied entry indices
  int mq[$];
  int m_wp;
  bit m_pend;
  bit m_kill;

  cr_ifu_ibuf_ctrl #(.ENTRY_NUM(N), .PTR_W(PW)) dut (
    .cpuclk             (cpuclk),
    .cpurst_b           (cpurst_b),
    .ibuf_flush         (ibuf_flush),
    .ifu_ibus_req       (ifu_ibus_req),
    .ibus_ifu_grant     (ibus_ifu_grant),
    .ibusif_xx_data_vld (ibusif_xx_data_vld),
    .ibus_half_only     (ibus_half_only),
    .dec_retire_vld     (dec_retire_vld),
    .dec_retire_32      (dec_retire_32),
    .entry_create0_en   (entry_create0_en),
    .entry_create1_en   (entry_create1_en),
    .entry_retire0_en   (entry_retire0_en),
    .entry_retire1_en   (entry_retire1_en),
    .ibuf_rptr          (ibuf_rptr),
    .ibuf_cnt           (ibuf_cnt),
    .ibuf_empty         (ibuf_empty),
    .ibuf_fetch_allow   (ibuf_fetch_allow),
    .ibuf_err           (ibuf_err)
  );

  // clock / reset
  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  typedef struct {
    logic       fl, req, gnt, dv, half, rv, r32;
    logic [7:0] c0, c1, r0, r1;
    logic [2:0] rptr;
    logic [3:0] cnt;
    logic       allow, err;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx % N] = 1'b1;
    return v;
  endfunction

  // driver tasks
  task automatic apply(input logic fl, input logic req, input logic gnt, input logic dv,
                       input logic half, input logic rv, input logic r32);
    ibuf_flush         = fl;
    ifu_ibus_req       = req;
    ibus_ifu_grant     = gnt;
    ibusif_xx_data_vld = dv;
    ibus_half_only     = half;
    dec_retire_vld     = rv;
    dec_retire_32      = r32;
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_wp   = 0;
    m_pend = 0;
    m_kill = 0;
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    cpurst_b = 1'b0;
    #1;
    model_reset();
    chk("rst_cnt", ibuf_cnt, 0);
    chk("rst_allow", ibuf_fetch_allow, 1);
    @(posedge cpuclk);
    #1;
    cpurst_b = 1'b1;
  endtask

  // scoreboard step: compare against model, clock, update model
  task automatic tick();
    int n, c, sz, fr;
    bit rok, cok, gerr;
    logic [N-1:0] e_c0, e_c1, e_r0, e_r1;
    sz   = mq.size();
    n    = (dec_retire_vld && !ibuf_flush) ? (dec_retire_32 ? 2 : 1) : 0;
    rok  = (n <= sz);
    c    = (ibusif_xx_data_vld && !m_kill && !ibuf_flush) ? (ibus_half_only ? 1 : 2) : 0;
    fr   = N - sz + (rok ? n : 0);
    cok  = (c <= fr);
    gerr = ifu_ibus_req && ibus_ifu_grant && m_pend;
    e_c0 = (cok && c >= 1) ? onehot(m_wp) : '0;
    e_c1 = (cok && c == 2) ? onehot(m_wp + 1) : '0;
    e_r0 = (rok && n >= 1) ? onehot(mq[0]) : '0;
    e_r1 = (rok && n == 2) ? onehot(mq[1]) : '0;
    chk("m_create0", entry_create0_en, e_c0);
    chk("m_create1", entry_create1_en, e_c1);
    chk("m_retire0", entry_retire0_en, e_r0);
    chk("m_retire1", entry_retire1_en, e_r1);
    chk("m_err", ibuf_err, ((n > 0 && !rok) || (c > 0 && !cok) || gerr) ? 1 : 0);
    chk("m_cnt", ibuf_cnt, sz);
    chk("m_rptr", ibuf_rptr, (sz > 0) ? mq[0] : m_wp);
    chk("m_empty", ibuf_empty, (sz == 0) ? 1 : 0);
    chk("m_allow", ibuf_fetch_allow, (!m_pend && sz <= N - 2) ? 1 : 0);
    @(posedge cpuclk);
    if (ibuf_flush) begin
      mq.delete();
      m_wp = 0;
      m_kill = m_pend && !ibusif_xx_data_vld;
    end else begin
      if (rok) for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (cok) for (int i = 0; i < c; i++) begin
        mq.push_back(m_wp);
        m_wp = (m_wp + 1) % N;
      end
      if (ibusif_xx_data_vld) m_kill = 0;
    end
    if (ifu_ibus_req && ibus_ifu_grant && !m_pend) m_pend = 1;
    else if (ibusif_xx_data_vld) m_pend = 0;
    #1;
  endtask

  initial begin
    int p_dv, p_rv;
    checks = 0;
    failures = 0;
    cpurst_b = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge cpuclk);
    #1;
    chk("reset_cnt", ibuf_cnt, 0);
    chk("reset_rptr", ibuf_rptr, 0);
    chk("reset_empty", ibuf_empty, 1);
    chk("reset_allow", ibuf_fetch_allow, 1);
    chk("reset_err", ibuf_err, 0);
    chk("reset_c0", entry_create0_en, 0);
    chk("reset_r0", entry_retire0_en, 0);
    cpurst_b = 1'b1;

    // fl req gnt dv half rv r32 | c0 c1 r0 r1 | rptr cnt allow err
    vt[0]  = '{0,1,1,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 3'd0,4'd0,1'b1,1'b0};
    vt[1]  = '{0,0,0,1,0,0,0, 8'h01,8'h02,8'h00,8'h00, 3'd0,4'd0,1'b0,1'b0};
    vt[2]  = '{0,1,1,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 3'd0,4'd2,1'b1,1'b0};
    vt[3]  = '{0,0,0,1,0,0,0, 8'h04,8'h08,8'h00,8'h00, 3'd0,4'd2,1'b0,1'b0};
    vt[4]  = '{0,1,1,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 3'd0,4'd4,1'b1,1'b0};
    vt[5]  = '{0,0,0,1,0,0,0, 8'h10,8'h20,8'h00,8'h00, 3'd0,4'd4,1'b0,1'b0};
    vt[6]  = '{0,0,0,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 3'd0,4'd6,1'b1,1'b0};
    vt[7]  = '{0,0,0,0,0,1,1, 8'h00,8'h00,8'h01,8'h02, 3'd0,4'd6,1'b1,1'b0};
    vt[8]  = '{0,0,0,0,0,1,1, 8'h00,8'h00,8'h04,8'h08, 3'd2,4'd4,1'b1,1'b0};
    vt[9]  = '{0,0,0,0,0,1,0, 8'h00,8'h00,8'h10,8'h00, 3'd4,4'd2,1'b1,1'b0};
    vt[10] = '{0,0,0,1,1,1,1, 8'h40,8'h00,8'h00,8'h00, 3'd5,4'd1,1'b1,1'b1};
    vt[11] = '{0,0,0,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 3'd5,4'd2,1'b1,1'b0};
    vt[12] = '{1,0,0,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 3'd5,4'd2,1'b1,1'b0};
    vt[13] = '{0,0,0,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 3'd0,4'd0,1'b1,1'b0};

    for (int i = 0; i < 14; i++) begin
      apply(vt[i].fl, vt[i].req, vt[i].gnt, vt[i].dv, vt[i].half, vt[i].rv, vt[i].r32);
      chk($sformatf("vec%0d_c0", i), entry_create0_en, vt[i].c0);
      chk($sformatf("vec%0d_c1", i), entry_create1_en, vt[i].c1);
      chk($sformatf("vec%0d_r0", i), entry_retire0_en, vt[i].r0);
      chk($sformatf("vec%0d_r1", i), entry_retire1_en, vt[i].r1);
      chk($sformatf("vec%0d_rptr", i), ibuf_rptr, vt[i].rptr);
      chk($sformatf("vec%0d_cnt", i), ibuf_cnt, vt[i].cnt);
      chk($sformatf("vec%0d_allow", i), ibuf_fetch_allow, vt[i].allow);
      chk($sformatf("vec%0d_err", i), ibuf_err, vt[i].err);
      tick();
    end

    // wrap: park both pointers at 7, then a full-word return straddles the end
    for (int i = 0; i < 7; i++) begin apply(0, 0, 0, 1, 1, 0, 0); tick(); end
    for (int i = 0; i < 7; i++) begin apply(0, 0, 0, 0, 0, 1, 0); tick(); end
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("wrap_c0", entry_create0_en, 8'h80);
    chk("wrap_c1", entry_create1_en, 8'h01);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_cnt", ibuf_cnt, 2);
    tick();
    apply(0, 0, 0, 0, 0, 1, 1);
    chk("wrap_r0", entry_retire0_en, 8'h80);
    chk("wrap_r1", entry_retire1_en, 8'h01);
    tick();

    // fill to 7, then full-word return with a 16-bit retire lands at 8
    for (int i = 0; i < 7; i++) begin apply(0, 0, 0, 1, 1, 0, 0); tick(); end
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("cnt7_allow", ibuf_fetch_allow, 0);
    tick();
    apply(0, 0, 0, 1, 0, 1, 0);
    chk("full_c0", entry_create0_en, 8'h01);
    chk("full_c1", entry_create1_en, 8'h02);
    chk("full_r0", entry_retire0_en, 8'h02);
    chk("full_err", ibuf_err, 0);
    tick();
    apply(0, 0, 0, 1, 1, 0, 0);
    chk("full_cnt", ibuf_cnt, 8);
    chk("full_empty", ibuf_empty, 0);
    chk("full_allow", ibuf_fetch_allow, 0);
    chk("full_ovf_err", ibuf_err, 1);
    chk("full_ovf_c0", entry_create0_en, 0);
    tick();
    apply(1, 0, 0, 0, 0, 0, 0); tick();

    // flush kills an outstanding fetch; its data is dropped
    apply(0, 1, 1, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("kill_c0", entry_create0_en, 0);
    chk("kill_c1", entry_create1_en, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("kill_cnt", ibuf_cnt, 0);
    chk("kill_allow", ibuf_fetch_allow, 1);
    tick();

    // flush coincident with data: no kill left behind
    apply(0, 1, 1, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 1, 0, 0, 0);
    chk("fldv_c0", entry_create0_en, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("fldv_allow", ibuf_fetch_allow, 1);
    tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("fldv_next_c0", entry_create0_en, 8'h01);
    tick();

    // reset mid-fetch clears pend; later data is accepted
    apply(0, 1, 1, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("midrst_pend_allow", ibuf_fetch_allow, 0);
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("midrst_allow", ibuf_fetch_allow, 1);
    tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("midrst_c0", entry_create0_en, 8'h01);
    tick();

    // random traffic in two load mixes
    for (int ph = 0; ph < 2; ph++) begin
      p_dv = (ph == 0) ? 35 : 60;
      p_rv = (ph == 0) ? 40 : 25;
      for (int i = 0; i < 400; i++) begin
        apply(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 99) < 30),
              ($urandom_range(0, 99) < 70),
              ($urandom_range(0, 99) < p_dv),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 99) < p_rv),
              ($urandom_range(0, 1) == 1));
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr_ifu_ibuf_ctrl.md
# cr_ifu_ibuf_ctrl

Pointer and occupancy controller for the IFU instruction buffer: a circular array of halfword ibuf entries. It turns instruction-bus returns into per-entry create0/create1 strobes and decoder consumption into per-entry retire0/retire1 strobes. It tracks read/write pointers and occupancy, and throttles fetch issue so that an outstanding fetch always has space to land. It sits between the IFU bus interface, the ibuf entry array and the decode stage.

## Interface
- ENTRY_NUM, 8, number of halfword entries; power of two, ≥4
- PTR_W, 3, log2(ENTRY_NUM)
- cpuclk  in  1  core clock; all state on rising edge
- cpurst_b  in  1  asynchronous active-low reset
- ibuf_flush  in  1  pipeline flush; empties buffer
- ifu_ibus_req  in  1  fetch request issued this cycle
- ibus_ifu_grant  in  1  bus accepted request this cycle
- ibusif_xx_data_vld  in  1  fetch data returned this cycle
- ibus_half_only  in  1  with data_vld: only upper halfword valid (misaligned target), one entry created
- dec_retire_vld  in  1  decoder consumes an instruction
- dec_retire_32  in  1  consumed instruction is 32-bit (two entries)
- entry_create0_en  out  ENTRY_NUM  one-hot, entry receiving first halfword
- entry_create1_en  out  ENTRY_NUM  one-hot, entry receiving second halfword
- entry_retire0_en  out  ENTRY_NUM  one-hot, entry at read pointer retired
- entry_retire1_en  out  ENTRY_NUM  one-hot, entry at read pointer+1 retired
- ibuf_rptr  out  PTR_W  head entry index
- ibuf_cnt  out  PTR_W+1  valid entries
- ibuf_empty  out  1  ibuf_cnt==0
- ibuf_fetch_allow  out  1  a new fetch may be issued
- ibuf_err  out  1  one-cycle pulse on protocol violation (overflow/underflow)

## Operation
- State: wptr, rptr (PTR_W, wrap modulo ENTRY_NUM), cnt (0..ENTRY_NUM), pend (outstanding granted fetch, 0/1), kill (outstanding fetch belongs to flushed stream).
- Create: data_vld & !kill & !flush → create0 one-hot at wptr; if !ibus_half_only also create1 one-hot at wptr+1. wptr advances by 1 or 2; cnt increases by same.
- Retire: dec_retire_vld & !flush → retire0 at rptr; if dec_retire_32 also retire1 at rptr+1. rptr advances by 1 or 2.
- Retire demand exceeding pre-cycle cnt (1 with cnt==0, 2 with cnt<2): no retire strobes, rptr/cnt unchanged, ibuf_err pulse.
- Create exceeding free space (ENTRY_NUM − cnt + retire this cycle): no create strobes, wptr/cnt unchanged, ibuf_err pulse.
- Simultaneous create and retire: both act; cnt_next = cnt + created − retired. Retire checks use pre-cycle cnt only (no same-cycle bypass).
- Outstanding: req & grant sets pend; data_vld clears pend. Grant while pend==1 is a bus-side error: ignored, ibuf_err pulse.
- ibuf_fetch_allow = !pend & (cnt ≤ ENTRY_NUM−2); combinational from registered state.
- Flush: wptr, rptr, cnt ← 0; all strobes low that cycle. If pend==1 and no data_vld that cycle, kill ← 1. Data returning with kill==1 is dropped (no create), clears pend and kill. Grant on flush cycle sets pend with kill=0 (new stream).
- Create and retire strobes are combinational, same cycle as data_vld/dec_retire_vld; the entry array registers them.

## Timing
- Reset: wptr=rptr=0, cnt=0, pend=0, kill=0. Outputs: ibuf_cnt=0, ibuf_rptr=0, ibuf_empty=1, ibuf_fetch_allow=1, ibuf_err=0, all strobes 0.
- Create strobe cycle N → entry valid, ibuf_cnt updated at N+1.
- Grant at N → fetch_allow low from N+1 until the cycle after data_vld.
- Wrap: wptr=ENTRY_NUM−1 with 2-halfword create → create0 bit ENTRY_NUM−1, create1 bit 0, wptr_next=1. Same rule for retire1.
- Full: cnt==ENTRY_NUM accepts retire only; cnt==ENTRY_NUM−1 blocks new fetch.
- Reset asserted mid-operation clears pend/kill; late data after reset release is taken as valid (bus reset in same domain).

## Test plan
- Reset, then three full-word returns → create pairs {0,1},{2,3},{4,5}; ibuf_cnt=6, fetch_allow=1 until cnt 7+.
- wptr=7, cnt=0, full-word return → create0=8'h80, create1=8'h01, wptr=1, ibuf_cnt=2; 32-bit retire then gives retire0=8'h80, retire1=8'h01.
- cnt=1, 32-bit retire → no strobes, ibuf_err one pulse, cnt stays 1; same cycle half_only create → cnt=2.
- cnt=7, full-word return with 16-bit retire same cycle → accepted, cnt=8, ibuf_empty=0, fetch_allow=0.
- Grant at cycle 2, flush at cycle 3, data_vld at cycle 5 → no create strobes, cnt=0, fetch_allow returns to 1 at cycle 6.
- Flush and data_vld in same cycle with pend=1 → no create, pend=0, kill stays 0.
